net_recv_dispatch_rr: RTL and testbench
=======================================

NET_RECV_DISPATCH_RR -- requirements
Module: net_recv_dispatch_rr

Interface
REQ-001 Parameter DATA_WIDTH, default 512: payload tdata width per beat.
REQ-002 Parameter KEEP_WIDTH, default 64: tkeep width, DATA_WIDTH/8.
REQ-003 Parameter NUM_INST, default 4: number of downstream handler instances, legal range 2..8.
REQ-004 Port clk  input  1: single clock, all logic on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port s_axis_tdata/tkeep/tlast/tvalid  input  DATA_WIDTH/KEEP_WIDTH/1/1: incoming NET_RECV packet stream.
REQ-007 Port s_axis_tready  output  1: backpressure to the NET_RECV source.
REQ-008 Port m_axis_tdata/tkeep/tlast  output  NUM_INST*DATA_WIDTH / NUM_INST*KEEP_WIDTH / NUM_INST: per-instance payload lanes; lane i occupies slice i.
REQ-009 Port m_axis_tvalid  output  NUM_INST: per-instance valid.
REQ-010 Port m_axis_tready  input  NUM_INST: per-instance ready.
REQ-011 Port inst_enable  input  NUM_INST: instance i eligible for new packets when bit i = 1.
REQ-012 Port grant_idx  output  3: index of the currently locked instance; 0 when idle.
REQ-013 Port busy  output  1: high while a packet is locked to an instance.

Function
REQ-014 Two states, IDLE and FWD; packets SHALL never be split across instances.
REQ-015 IDLE: s_axis_tready = 0 and all m_axis_tvalid = 0.
REQ-016 IDLE, s_axis_tvalid = 1 and inst_enable != 0: register grant = first enabled index searching ptr, ptr+1, ... mod NUM_INST; next state FWD.
REQ-017 IDLE, inst_enable = 0: remain IDLE, no beat consumed, ptr unchanged.
REQ-018 FWD: m_axis_tvalid[grant] = s_axis_tvalid, all other valid bits 0, s_axis_tready = m_axis_tready[grant]; combinational pass-through, zero beat latency.
REQ-019 All lanes' tdata/tkeep/tlast SHALL carry the s_axis values; only the valid bits differ.
REQ-020 FWD, handshake (s_axis_tvalid & s_axis_tready) with tlast = 1: ptr <= (grant+1) mod NUM_INST, next state IDLE.
REQ-021 Arbitration bubble: exactly one cycle in IDLE between packets; first beat of a packet is accepted no earlier than the cycle after its tvalid is first seen in IDLE.
REQ-022 inst_enable changes during FWD SHALL be ignored until the packet ends; a disabled instance finishes its current packet.
REQ-023 Single-beat packet (tlast on first beat) SHALL follow the same IDLE->FWD->IDLE path.
REQ-024 Source withdrawing tvalid mid-packet: stay FWD, grant held.
REQ-025 ptr wraps NUM_INST-1 -> 0.
REQ-026 grant_idx = grant in FWD, 0 in IDLE; busy = 1 exactly in FWD.

Reset
REQ-027 rst = 1 at a clock edge: state IDLE, ptr = 0, grant = 0; takes priority over all other events.
REQ-028 Outputs during and after reset: s_axis_tready = 0, m_axis_tvalid = 0, busy = 0, grant_idx = 0, stat_pkt_count = 0 (if present).
REQ-029 Reset mid-packet SHALL abandon the packet; remaining beats are dispatched as a new packet after reset.

Configuration
REQ-030 Macro NET_RECV_DISPATCH_STATS_EN defined: output port stat_pkt_count (32 bits) increments by 1 on every tlast handshake, wraps 0xFFFFFFFF -> 0.
REQ-031 Macro undefined: port stat_pkt_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 NUM_INST=4, all enabled, all ready, 8 single-beat packets back-to-back -> valid on lanes 0,1,2,3,0,1,2,3 and one idle cycle between packets.
REQ-033 inst_enable=4'b1010, 3 packets of 3 beats each -> grants 1,3,1, every beat on one lane, no interleaving.
REQ-034 Packet on lane 2, m_axis_tready[2]=0 for 5 cycles mid-packet -> s_axis_tready=0 for those 5 cycles, no beat lost or duplicated, other lanes valid 0.
REQ-035 inst_enable=0 with s_axis_tvalid=1 for 10 cycles, then 4'b0001 -> no acceptance for 10 cycles, then packet to lane 0.
REQ-036 rst asserted on beat 2 of a 4-beat packet on lane 1 -> next cycle busy=0, ptr=0; following packet granted to lane 0.
REQ-037 With NET_RECV_DISPATCH_STATS_EN, counter preloaded by forcing to 0xFFFFFFFE, 2 packets -> stat_pkt_count reads 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/net_recv_dispatch_rr.sv
// rtl/net_recv_dispatch_rr.sv - round-robin packet dispatcher from one NET_RECV stream to NUM_INST handler lanes
// Optional feature: define NET_RECV_DISPATCH_STATS_EN to add the stat_pkt_count packet counter.
module net_recv_dispatch_rr #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int NUM_INST   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [NUM_INST*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_INST*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [NUM_INST-1:0]            m_axis_tlast,
    output logic [NUM_INST-1:0]            m_axis_tvalid,
    input  logic [NUM_INST-1:0]            m_axis_tready,
    input  logic [NUM_INST-1:0]            inst_enable,
`ifdef NET_RECV_DISPATCH_STATS_EN
    output logic [31:0]                    stat_pkt_count,
`endif
    output logic [2:0]                     grant_idx,
    output logic                           busy
);

    typedef enum logic {IDLE, FWD} state_t;

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] ptr_q, ptr_d;

    // Zero-extended copies so a 3-bit index always fits regardless of NUM_INST.
    logic [7:0] en_ext;
    logic [7:0] rdy_ext;
    logic       last_hs;
    logic       pick_found;
    logic [2:0] pick_idx;

    assign en_ext  = 8'(inst_enable);
    assign rdy_ext = 8'(m_axis_tready);
    assign last_hs = s_axis_tvalid & s_axis_tready & s_axis_tlast;

    // Every lane sees the same payload; only the valid bit selects the receiver.
    assign m_axis_tdata = {NUM_INST{s_axis_tdata}};
    assign m_axis_tkeep = {NUM_INST{s_axis_tkeep}};
    assign m_axis_tlast = {NUM_INST{s_axis_tlast}};

    // First enabled instance searching ptr, ptr+1, ... (descending loop so the nearest wins).
    always_comb begin
        logic [3:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_INST - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NUM_INST)) begin
                cand = cand - 4'(NUM_INST);
            end
            if (en_ext[cand[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: lock a lane in IDLE, release it on the last beat's handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid && pick_found) begin
                    grant_d = pick_idx;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (last_hs) begin
                    ptr_d   = (grant_q == 3'(NUM_INST - 1)) ? 3'd0 : grant_q + 3'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: combinational pass-through to the locked lane; forced quiet while reset is held.
    always_comb begin
        m_axis_tvalid = '0;
        s_axis_tready = 1'b0;
        busy          = 1'b0;
        grant_idx     = '0;
        if (state_q == FWD && !rst) begin
            busy          = 1'b1;
            grant_idx     = grant_q;
            s_axis_tready = rdy_ext[grant_q];
            for (int i = 0; i < NUM_INST; i++) begin
                if (grant_q == 3'(i)) begin
                    m_axis_tvalid[i] = s_axis_tvalid;
                end
            end
        end
    end

`ifdef NET_RECV_DISPATCH_STATS_EN
    logic [31:0] stat_cnt_q;

    // Completed-packet counter, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_q <= '0;
        end else if (last_hs) begin
            stat_cnt_q <= stat_cnt_q + 32'd1;
        end
    end

    assign stat_pkt_count = rst ? 32'd0 : stat_cnt_q;
`endif

endmodule

// File: tb/tb_net_recv_dispatch_rr.sv
// tb/tb_net_recv_dispatch_rr.sv - randomized and directed self-checking bench for net_recv_dispatch_rr
module tb_net_recv_dispatch_rr;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   s_tdata = '0;
    logic [KW-1:0]   s_tkeep = '0;
    logic            s_tlast = 1'b0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [N*DW-1:0] m_tdata;
    logic [N*KW-1:0] m_tkeep;
    logic [N-1:0]    m_tlast;
    logic [N-1:0]    m_tvalid;
    logic [N-1:0]    m_tready = '1;
    logic [N-1:0]    inst_en = '1;
    logic [2:0]      grant_idx;
    logic            busy;
`ifdef NET_RECV_DISPATCH_STATS_EN
    logic [31:0]     stat_pkt_count;
`endif

    net_recv_dispatch_rr #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_INST(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .inst_enable   (inst_en),
`ifdef NET_RECV_DISPATCH_STATS_EN
        .stat_pkt_count(stat_pkt_count),
`endif
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which lane holds the current packet (-1 = none), the rotation start, packet count.
    int          m_lane = -1;
    int          m_ptr  = 0;
    logic [31:0] m_cnt  = '0;

    // Source: packets of src_len beats, src_beat is the next beat to send.
    bit src_on   = 1'b0;
    bit rnd_mode = 1'b0;
    int src_len  = 1;
    int src_beat = 0;
    int pkts_done = 0;

    int lane_log[$];
    int lane_beats[N];
    int total_beats = 0;
    int stall_cnt = 0;
    int ncyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_enabled(input int p, input logic [N-1:0] en);
        for (int k = 0; k < N; k++) begin
            if (en[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        s_tvalid = src_on && (rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
        s_tlast  = (src_beat == src_len - 1);
        s_tdata  = {16'(pkts_done), 16'(src_beat)};
        s_tkeep  = KW'($urandom);
        if (rnd_mode) begin
            m_tready = N'($urandom);
            inst_en  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] ev;
        bit           hs;
        bit           lk;
        int           k;
        drive();
        @(negedge clk);
        lk = !rst && (m_lane >= 0);
        ev = '0;
        if (lk && s_tvalid) ev[m_lane] = 1'b1;
        check("busy", 64'(busy), 64'(lk));
        check("grant_idx", 64'(grant_idx), lk ? 64'(m_lane) : 64'd0);
        check("s_tready", 64'(s_tready), lk ? 64'(m_tready[m_lane]) : 64'd0);
        check("m_tvalid", 64'(m_tvalid), 64'(ev));
        k = $urandom_range(0, N - 1);
        check("lane_data", 64'(m_tdata[k*DW +: DW]), 64'(s_tdata));
        check("lane_keep", 64'(m_tkeep[k*KW +: KW]), 64'(s_tkeep));
        check("lane_last", 64'(m_tlast), 64'({N{s_tlast}}));
`ifdef NET_RECV_DISPATCH_STATS_EN
        check("stat_cnt", 64'(stat_pkt_count), rst ? 64'd0 : 64'(m_cnt));
`endif
        hs = s_tvalid && s_tready;
        if (hs) begin
            for (int i = 0; i < N; i++) begin
                if (m_tvalid[i] && m_tready[i]) begin
                    lane_beats[i]++;
                    total_beats++;
                    if (s_tlast) lane_log.push_back(i);
                end
            end
        end
        if (busy && s_tvalid && !s_tready) stall_cnt++;
        if (rst) begin
            m_lane = -1;
            m_ptr  = 0;
            m_cnt  = '0;
        end else if (m_lane < 0) begin
            if (s_tvalid && inst_en != '0) m_lane = first_enabled(m_ptr, inst_en);
        end else if (s_tvalid && m_tready[m_lane] && s_tlast) begin
            m_ptr  = (m_lane + 1) % N;
            m_lane = -1;
            m_cnt  = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        if (hs) begin
            if (s_tlast) begin
                src_beat = 0;
                pkts_done++;
                if (rnd_mode) src_len = $urandom_range(1, 4);
            end else begin
                src_beat++;
            end
        end
    endtask

    task automatic do_reset();
        src_on = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        src_beat = 0;
        pkts_done = 0;
        total_beats = 0;
        stall_cnt = 0;
        lane_log.delete();
        for (int i = 0; i < N; i++) lane_beats[i] = 0;
        m_tready = '1;
    endtask

    task automatic run_until(input int target, input int budget, input string tag, output int n);
        n = 0;
        while (pkts_done < target && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(pkts_done >= target), 64'd1);
    endtask

    task automatic wait_beat(input int b, input int budget, input string tag);
        int n = 0;
        while (src_beat < b && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(src_beat >= b), 64'd1);
    endtask

    initial begin
        // Reset values, held for a few cycles.
        repeat (3) cycle();
        do_reset();

        // Back-to-back single-beat packets rotate over all lanes with one bubble each.
        inst_en = 4'b1111; src_len = 1; src_on = 1'b1;
        run_until(8, 40, "rr_timeout", ncyc);
        src_on = 1'b0;
        check("rr_cycles", 64'(ncyc), 64'd16);
        for (int i = 0; i < 8; i++) begin
            check("rr_lane", (i < lane_log.size()) ? 64'(lane_log[i]) : 64'hdead, 64'(i % N));
        end

        // Sparse enable: only lanes 1 and 3 take packets.
        do_reset();
        inst_en = 4'b1010; src_len = 3; src_on = 1'b1;
        run_until(3, 60, "sparse_timeout", ncyc);
        src_on = 1'b0;
        check("sparse_n", 64'(lane_log.size()), 64'd3);
        if (lane_log.size() == 3) begin
            check("sparse_g0", 64'(lane_log[0]), 64'd1);
            check("sparse_g1", 64'(lane_log[1]), 64'd3);
            check("sparse_g2", 64'(lane_log[2]), 64'd1);
        end
        check("sparse_l1", 64'(lane_beats[1]), 64'd6);
        check("sparse_l3", 64'(lane_beats[3]), 64'd3);

        // Downstream stall on lane 2 for five cycles mid-packet.
        do_reset();
        inst_en = 4'b0100; src_len = 4; src_on = 1'b1;
        wait_beat(1, 10, "stall_start");
        m_tready = 4'b1011;
        stall_cnt = 0;
        repeat (5) cycle();
        m_tready = 4'b1111;
        run_until(1, 20, "stall_timeout", ncyc);
        src_on = 1'b0;
        check("stall_cycles", 64'(stall_cnt), 64'd5);
        check("stall_l2", 64'(lane_beats[2]), 64'd4);
        check("stall_total", 64'(total_beats), 64'd4);

        // No instance enabled: nothing accepted until one appears.
        do_reset();
        inst_en = 4'b0000; src_len = 2; src_on = 1'b1;
        repeat (10) cycle();
        check("noen_beats", 64'(total_beats), 64'd0);
        inst_en = 4'b0001;
        run_until(1, 10, "noen_timeout", ncyc);
        src_on = 1'b0;
        check("noen_l0", 64'(lane_beats[0]), 64'd2);

        // Reset in the middle of a packet on lane 1; the remainder goes to lane 0.
        do_reset();
        inst_en = 4'b1111; src_len = 1; src_on = 1'b1;
        run_until(1, 10, "mid_pre", ncyc);
        src_len = 4;
        wait_beat(1, 10, "mid_beat1");
        check("mid_l1", 64'(lane_beats[1]), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_busy", 64'(busy), 64'd0);
        run_until(2, 20, "mid_timeout", ncyc);
        src_on = 1'b0;
        check("mid_lane", 64'(lane_log[lane_log.size()-1]), 64'd0);
        check("mid_l0", 64'(lane_beats[0]), 64'd4);

`ifdef NET_RECV_DISPATCH_STATS_EN
        // Counter wrap from a forced preload.
        do_reset();
        force dut.stat_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.stat_cnt_q;
        m_cnt = 32'hFFFFFFFE;
        inst_en = 4'b1111; src_len = 1; src_on = 1'b1;
        run_until(1, 10, "stat_t1", ncyc);
        check("stat_ff", 64'(stat_pkt_count), 64'hFFFFFFFF);
        run_until(2, 10, "stat_t2", ncyc);
        src_on = 1'b0;
        check("stat_wrap", 64'(stat_pkt_count), 64'h0);
`endif

        // Random traffic, random readiness/enables, occasional reset.
        do_reset();
        rnd_mode = 1'b1; src_len = 2; src_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        check("rnd_progress", 64'(pkts_done > 50), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
